vending_machine_chg: RTL and testbench
======================================

Name: vending_machine_chg

Overview:
- Parametrised successor to the nickel/dime/quarter candy vending controller.
- Accepts one coin per cycle and vends when credit reaches a configurable PRICE.
- Returns change, or refunds on cancel, as a serial stream of dime/nickel pulses.
- Rejects illegal coin inputs and keeps a wrapping sales count. Sits between the coin-sense front end and the dispenser/coin-return actuators.

Parameters:
PRICE, 15, item price in cents; nonzero multiple of 5
CREDIT_W, 7, credit register width; must satisfy 2^CREDIT_W-1 >= PRICE+20
CNT_W, 8, sales counter width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
n  input  1  nickel (5c) sensed this cycle
d  input  1  dime (10c) sensed this cycle
q  input  1  quarter (25c) sensed this cycle
cancel  input  1  refund request
y  output  1  vend pulse, one cycle per item
chg_n  output  1  return one nickel this cycle
chg_d  output  1  return one dime this cycle
coin_rej  output  1  previous-cycle coin input was rejected
busy  output  1  machine not accepting coins
credit  output  CREDIT_W  current credit/outstanding change in cents
sales  output  CNT_W  items vended, wraps modulo 2^CNT_W

Behaviour:
- Interface:
  - One clock.
  - reset is asynchronous and active-low.
  - All other inputs are synchronous to clk.
- Reset (reset=0, any time, including mid-VEND/CHANGE):
  - state=IDLE.
  - credit=0, sales=0, coin_rej=0.
  - y=chg_n=chg_d=busy=0 immediately.
  - Pending change is discarded.
- States: IDLE, VEND, CHANGE. Output decode:
  - y=1 only in VEND.
  - busy=1 in VEND and CHANGE.
  - chg_d=(state==CHANGE && credit>=10).
  - chg_n=(state==CHANGE && credit==5).
  - chg_d and chg_n are mutually exclusive.
- Valid coin: exactly one of n/d/q high at a rising edge while in IDLE and cancel=0.
- IDLE, valid coin:
  - sum = credit + {5,10,25}.
  - If sum >= PRICE: credit <= sum-PRICE, state <= VEND, sales <= sales+1.
  - Else credit <= sum and the state stays IDLE.
  - In IDLE, credit < PRICE always holds.
- IDLE, cancel=1:
  - If credit>0: state <= CHANGE (refund, no vend, sales unchanged).
  - If credit==0: no effect.
  - Any coin in the same cycle is rejected.
- VEND (exactly one cycle): state <= CHANGE if credit>0, else IDLE.
- CHANGE, one coin per cycle, largest first:
  - credit>=10: credit -= 10.
  - credit==5: credit -= 5.
  - When the decremented credit is 0, state <= IDLE.
  - Latency for C cents of change: ceil(C/10) cycles.
- Rejection:
  - A coin input is rejected if:
    - two or more of n/d/q are high, or
    - a coin is high while state!=IDLE, or
    - a coin is high with cancel=1.
  - On rejection: coin_rej=1 for exactly the next cycle; credit and state are unaffected by the coin.
  - coin_rej is registered.
- Cancel in VEND/CHANGE: ignored.
- sales wraps from 2^CNT_W-1 to 0 without a flag.
- Credit arithmetic is unsigned CREDIT_W bits; no overflow is possible given the parameter constraint.

Test Plan:
- PRICE=15:
  - Stimulus: n, then d, then idle.
  - Credit: 5 → 15.
  - Response: y=1 for one cycle after the d edge, then IDLE.
  - chg_n=chg_d=0, credit=0, sales=1.
- PRICE=15, reset sequence:
  - Stimulus: d, d.
  - Credit: 10 → 20 ≥ 15.
  - Response: y pulse, then chg_n=1 for one cycle, credit 5 → 0.
  - busy high for 2 cycles, sales=1.
- PRICE=15:
  - Stimulus: d, q.
  - Credit: 35, change 20.
  - Response: y, then chg_d on two consecutive cycles (credit 20 → 10 → 0), then IDLE.
- PRICE=15, refund:
  - Stimulus: n, n, then cancel.
  - Credit: 10.
  - Response: no y; chg_d=1 for one cycle; credit=0; sales unchanged.
- Rejection:
  - n&d together in IDLE → coin_rej pulse next cycle, credit unchanged.
  - q during CHANGE → coin_rej, change sequence unaffected.
  - cancel+n with credit 0 → coin_rej, no change pulses.
- Reset and parameter checks:
  - Drive reset low mid-CHANGE with 20c pending → outputs drop to 0 asynchronously; after release the machine is IDLE with credit=0.
  - Separate build PRICE=40, CNT_W=2: q, q → y and chg_d once.
  - Repeat the PRICE=40 vend 4 times → sales wraps 3 → 0.

Source files
------------

// File: rtl/vending_machine_chg_if.sv
// Coin-sense / actuator bundle for the vending controller, plus a state
// debug view so checkers can follow the FSM directly.
interface vending_machine_chg_if #(
    parameter int CREDIT_W = 7,
    parameter int CNT_W    = 8
);
    // Coin pulses and cancel are level-sampled once per rising edge; there is
    // no back-pressure: busy only says coins seen now will be rejected.
    logic                n;
    logic                d;
    logic                q;
    logic                cancel;
    logic                y;
    logic                chg_n;
    logic                chg_d;
    logic                coin_rej;
    logic                busy;
    logic [CREDIT_W-1:0] credit;
    logic [CNT_W-1:0]    sales;
    logic [1:0]          state_dbg;

    modport master (
        output n, d, q, cancel,
        input  y, chg_n, chg_d, coin_rej, busy, credit, sales, state_dbg
    );

    modport slave (
        input  n, d, q, cancel,
        output y, chg_n, chg_d, coin_rej, busy, credit, sales, state_dbg
    );
endinterface

// File: rtl/vending_machine_chg.sv
// Coin-operated vend controller: accumulates credit, vends at PRICE and pays
// change or refunds as a dime-first serial stream of return pulses.
module vending_machine_chg #(
    parameter int PRICE    = 15,
    parameter int CREDIT_W = 7,
    parameter int CNT_W    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    vending_machine_chg_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VEND   = 2'd1,
        CHANGE = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] FIVE    = CREDIT_W'(5);
    localparam logic [CREDIT_W-1:0] TEN     = CREDIT_W'(10);
    localparam logic [CREDIT_W-1:0] QUARTER = CREDIT_W'(25);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CNT_W-1:0]    sales_q, sales_d;
    logic                rej_q, rej_d;

    logic [1:0]          coin_cnt;
    logic                valid_coin;
    logic [CREDIT_W-1:0] coin_val;
    logic [CREDIT_W-1:0] sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            credit_q <= '0;
            sales_q  <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            sales_q  <= sales_d;
            rej_q    <= rej_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        sales_d    = sales_q;
        coin_cnt   = {1'b0, bus.n} + {1'b0, bus.d} + {1'b0, bus.q};
        valid_coin = (state_q == IDLE) && !bus.cancel && (coin_cnt == 2'd1);
        coin_val   = bus.n ? FIVE : (bus.d ? TEN : QUARTER);
        sum        = credit_q + coin_val;
        // Any coin that is not a valid one is rejected; that covers multiple
        // coins, coins while busy, and coins alongside cancel.
        rej_d      = (coin_cnt != 2'd0) && !valid_coin;

        case (state_q)
            IDLE: begin
                if (valid_coin) begin
                    if (sum >= PRICE_C) begin
                        credit_d = sum - PRICE_C;
                        sales_d  = sales_q + 1'b1;
                        state_d  = VEND;
                    end else begin
                        credit_d = sum;
                    end
                end else if (bus.cancel && (credit_q != '0)) begin
                    state_d = CHANGE;
                end
            end
            VEND: begin
                state_d = (credit_q != '0) ? CHANGE : IDLE;
            end
            CHANGE: begin
                // Credit here is always a nonzero multiple of 5, so below ten
                // means exactly one nickel left.
                if (credit_q >= TEN) begin
                    credit_d = credit_q - TEN;
                end else begin
                    credit_d = '0;
                end
                if (credit_d == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign bus.y         = (state_q == VEND);
    assign bus.busy      = (state_q != IDLE);
    assign bus.chg_d     = (state_q == CHANGE) && (credit_q >= TEN);
    assign bus.chg_n     = (state_q == CHANGE) && (credit_q == FIVE);
    assign bus.coin_rej  = rej_q;
    assign bus.credit    = credit_q;
    assign bus.sales     = sales_q;
    assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_vending_machine_chg.sv
// Bench for vending_machine_chg: PRICE=15 vector table, hand sequences for
// reset and a PRICE=40/CNT_W=2 build, then random traffic against a model.
module tb_vending_machine_chg;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    always #10 clk = ~clk;

    vending_machine_chg_if #(.CREDIT_W(7), .CNT_W(8)) bus15 ();
    vending_machine_chg_if #(.CREDIT_W(7), .CNT_W(2)) bus40 ();

    vending_machine_chg #(.PRICE(15), .CREDIT_W(7), .CNT_W(8)) dut15 (
        .clk(clk), .reset(rst_n), .bus(bus15.slave)
    );
    vending_machine_chg #(.PRICE(40), .CREDIT_W(7), .CNT_W(2)) dut40 (
        .clk(clk), .reset(rst_n), .bus(bus40.slave)
    );

    // Reference model for PRICE=15: credit held while idle, a pending vend
    // flag, and the change still owed as a queue of coin values.
    int         m_credit;
    int         m_sales;
    bit         m_vend;
    bit         m_rej;
    logic [4:0] exp_q[$];

    typedef struct {
        logic n, d, q, c;
        logic y, cd, cn;
        int   cr;
        logic busy, rej;
        int   sales;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void load_change(input int c);
        for (int i = 0; i < c / 10; i++) exp_q.push_back(5'd10);
        if (c % 10 != 0) exp_q.push_back(5'd5);
    endfunction

    function automatic void model_reset();
        m_credit = 0;
        m_sales  = 0;
        m_vend   = 0;
        m_rej    = 0;
        exp_q.delete();
    endfunction

    function automatic void model_step(input bit n, input bit d, input bit q, input bit c);
        int  coins;
        bit  idle;
        int  v;
        int  s;
        coins = int'(n) + int'(d) + int'(q);
        idle  = !m_vend && (exp_q.size() == 0);
        m_rej = (coins > 0) && ((coins > 1) || !idle || c);
        if (m_vend) begin
            m_vend = 0;
        end else if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end else if (coins == 1 && !c) begin
            v = n ? 5 : (d ? 10 : 25);
            s = m_credit + v;
            if (s >= 15) begin
                m_vend   = 1;
                m_sales  = (m_sales + 1) % 256;
                m_credit = 0;
                load_change(s - 15);
            end else begin
                m_credit = s;
            end
        end else if (c && m_credit > 0) begin
            load_change(m_credit);
            m_credit = 0;
        end
    endfunction

    task automatic check_model();
        int  owed;
        bit  busy_e;
        owed = 0;
        foreach (exp_q[i]) owed += int'(exp_q[i]);
        busy_e = m_vend || (exp_q.size() > 0);
        chk("model_y", int'(bus15.y), int'(m_vend));
        chk("model_chg_d", int'(bus15.chg_d), int'(!m_vend && exp_q.size() > 0 && exp_q[0] == 5'd10));
        chk("model_chg_n", int'(bus15.chg_n), int'(!m_vend && exp_q.size() > 0 && exp_q[0] == 5'd5));
        chk("model_credit", int'(bus15.credit), busy_e ? owed : m_credit);
        chk("model_busy", int'(bus15.busy), int'(busy_e));
        chk("model_coin_rej", int'(bus15.coin_rej), int'(m_rej));
        chk("model_sales", int'(bus15.sales), m_sales);
    endtask

    // Entered and left at a falling edge: drive, let one rising edge pass,
    // then compare against the model.
    task automatic apply(input bit n, input bit d, input bit q, input bit c);
        bus15.n = n; bus15.d = d; bus15.q = q; bus15.cancel = c;
        model_step(n, d, q, c);
        @(negedge clk);
        check_model();
    endtask

    task automatic apply40(input bit n, input bit d, input bit q);
        bus40.n = n; bus40.d = d; bus40.q = q; bus40.cancel = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0);
        bus40.n = 1'b0; bus40.d = 1'b0; bus40.q = 1'b0;
    endtask

    function automatic void add(input logic n, d, q, c, y, cd, cn, input int cr,
                                input logic busy, rej, input int sales);
        vec_t v;
        v.n = n; v.d = d; v.q = q; v.c = c;
        v.y = y; v.cd = cd; v.cn = cn; v.cr = cr;
        v.busy = busy; v.rej = rej; v.sales = sales;
        tbl.push_back(v);
    endfunction

    initial begin
        bus15.n = 0; bus15.d = 0; bus15.q = 0; bus15.cancel = 0;
        bus40.n = 0; bus40.d = 0; bus40.q = 0; bus40.cancel = 0;
        model_reset();

        //   n d q c   y cd cn cr  bsy rej sales
        add(1,0,0,0, 0,0,0, 5, 0,0,0);
        add(0,1,0,0, 1,0,0, 0, 1,0,1);
        add(0,0,0,0, 0,0,0, 0, 0,0,1);
        add(0,1,0,0, 0,0,0,10, 0,0,1);
        add(0,1,0,0, 1,0,0, 5, 1,0,2);
        add(0,0,0,0, 0,0,1, 5, 1,0,2);
        add(0,0,0,0, 0,0,0, 0, 0,0,2);
        add(0,1,0,0, 0,0,0,10, 0,0,2);
        add(0,0,1,0, 1,0,0,20, 1,0,3);
        add(0,0,0,0, 0,1,0,20, 1,0,3);
        add(0,0,0,0, 0,1,0,10, 1,0,3);
        add(0,0,0,0, 0,0,0, 0, 0,0,3);
        add(1,0,0,0, 0,0,0, 5, 0,0,3);
        add(1,0,0,0, 0,0,0,10, 0,0,3);
        add(0,0,0,1, 0,1,0,10, 1,0,3);
        add(0,0,0,0, 0,0,0, 0, 0,0,3);
        add(1,0,0,0, 0,0,0, 5, 0,0,3);
        add(1,1,0,0, 0,0,0, 5, 0,1,3);
        add(0,0,0,0, 0,0,0, 5, 0,0,3);
        add(0,1,0,0, 1,0,0, 0, 1,0,4);
        add(0,0,0,0, 0,0,0, 0, 0,0,4);
        add(0,1,0,0, 0,0,0,10, 0,0,4);
        add(0,0,1,0, 1,0,0,20, 1,0,5);
        add(0,0,0,0, 0,1,0,20, 1,0,5);
        add(0,0,1,0, 0,1,0,10, 1,1,5);
        add(0,0,0,0, 0,0,0, 0, 0,0,5);
        add(1,0,0,1, 0,0,0, 0, 0,1,5);
        add(0,0,0,0, 0,0,0, 0, 0,0,5);

        repeat (3) @(negedge clk);
        chk("rst_y", int'(bus15.y), 0);
        chk("rst_busy", int'(bus15.busy), 0);
        chk("rst_credit", int'(bus15.credit), 0);
        chk("rst_sales", int'(bus15.sales), 0);
        chk("rst_coin_rej", int'(bus15.coin_rej), 0);
        chk("rst40_sales", int'(bus40.sales), 0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].n, tbl[i].d, tbl[i].q, tbl[i].c);
            chk($sformatf("tbl%0d_y", i), int'(bus15.y), int'(tbl[i].y));
            chk($sformatf("tbl%0d_chg_d", i), int'(bus15.chg_d), int'(tbl[i].cd));
            chk($sformatf("tbl%0d_chg_n", i), int'(bus15.chg_n), int'(tbl[i].cn));
            chk($sformatf("tbl%0d_credit", i), int'(bus15.credit), tbl[i].cr);
            chk($sformatf("tbl%0d_busy", i), int'(bus15.busy), int'(tbl[i].busy));
            chk($sformatf("tbl%0d_coin_rej", i), int'(bus15.coin_rej), int'(tbl[i].rej));
            chk($sformatf("tbl%0d_sales", i), int'(bus15.sales), tbl[i].sales);
        end

        // Reset in the middle of paying 20c of change.
        apply(0, 1, 0, 0);
        apply(0, 0, 1, 0);
        apply(0, 0, 0, 0);
        chk("midchg_credit", int'(bus15.credit), 20);
        #5 rst_n = 1'b0;
        #1;
        chk("arst_y", int'(bus15.y), 0);
        chk("arst_chg_d", int'(bus15.chg_d), 0);
        chk("arst_chg_n", int'(bus15.chg_n), 0);
        chk("arst_busy", int'(bus15.busy), 0);
        chk("arst_credit", int'(bus15.credit), 0);
        chk("arst_sales", int'(bus15.sales), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        apply(0, 0, 0, 0);
        chk("post_rst_state", int'(bus15.state_dbg), 0);

        // PRICE=40, CNT_W=2: q,q vends with 10c change; four vends wrap sales.
        for (int k = 1; k <= 4; k++) begin
            apply40(0, 0, 1);
            chk("p40_credit25", int'(bus40.credit), 25);
            apply40(0, 0, 1);
            chk("p40_y", int'(bus40.y), 1);
            chk("p40_sales", int'(bus40.sales), k % 4);
            apply40(0, 0, 0);
            chk("p40_chg_d", int'(bus40.chg_d), 1);
            chk("p40_chg_n", int'(bus40.chg_n), 0);
            apply40(0, 0, 0);
            chk("p40_idle_busy", int'(bus40.busy), 0);
            chk("p40_idle_credit", int'(bus40.credit), 0);
        end

        for (int i = 0; i < 500; i++) begin
            apply($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
        end
        apply(0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
